mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 15, giving the memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, giving the memory data width.
REQ-003 The block SHALL have parameter RD_LAT, default 1, legal range 1..3, giving the cycles from mem_addr presented to mem_rdata valid.
REQ-004 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have ports r0_req / r1_req, input, 1, access request from requester 0 (core) / 1 (secondary: loader or display).
REQ-007 The block SHALL have ports r0_addr / r1_addr, input, ADDR_W, request address.
REQ-008 The block SHALL have ports r0_wdata / r1_wdata, input, DATA_W, write data.
REQ-009 The block SHALL have ports r0_we / r1_we, input, 1, 1 = write, 0 = read.
REQ-010 The block SHALL have ports r0_gnt / r1_gnt, output, 1, combinational grant, same cycle as the request.
REQ-011 The block SHALL have ports r0_rvalid / r1_rvalid, output, 1, read data return strobe.
REQ-012 The block SHALL have ports r0_rdata / r1_rdata, output, DATA_W, read data, meaningful only while the matching rvalid is 1.
REQ-013 The block SHALL have port mem_addr, output, ADDR_W, registered memory address.
REQ-014 The block SHALL have port mem_wdata, output, DATA_W, registered memory write data.
REQ-015 The block SHALL have port mem_we, output, 1, registered memory write enable.
REQ-016 The block SHALL have port mem_rdata, input, DATA_W, memory read data.

Function
REQ-017 The block SHALL issue at most one memory access per cycle and assert at most one gnt per cycle.
REQ-018 The requester SHALL hold req/addr/wdata/we stable until it samples gnt=1; the access completes at that rising edge.
REQ-019 With one requester active, the block SHALL grant it every cycle: back-to-back, 1 access/cycle.
REQ-020 With both active, the block SHALL grant the requester not granted most recently; the last-granted pointer updates only on a grant.
REQ-021 gnt SHALL be 0 when the corresponding req is 0 and whenever reset is 1.
REQ-022 On a grant in cycle N, the block SHALL register addr, wdata and we into mem_addr, mem_wdata and mem_we, visible in cycle N+1.
REQ-023 In a cycle with no grant, the block SHALL drive mem_we=0 in the next cycle and mem_addr/mem_wdata SHALL hold their previous values.
REQ-024 For a read granted in cycle N, the block SHALL assert the granted port's rvalid for exactly one cycle, N+1+RD_LAT, with rdata equal to mem_rdata in that cycle.
REQ-025 The block SHALL carry read returns in an RD_LAT+1-deep tag pipeline (valid, id).
REQ-026 Returns SHALL stay in grant order; overlapping reads from both ports SHALL each return to the correct port.
REQ-027 A write SHALL produce no rvalid.
REQ-028 A read and a write to the same address SHALL take effect at memory in grant order.
REQ-029 rdata SHALL be driven from mem_rdata on both ports; only rvalid is steered.

Reset
REQ-030 While reset=1 at a rising edge, the block SHALL set mem_we=0, mem_addr=0, mem_wdata=0.
REQ-031 While reset=1 at a rising edge, the block SHALL clear all tag pipeline entries, so r0_rvalid=r1_rvalid=0 from the next cycle.
REQ-032 While reset=1 at a rising edge, the block SHALL set the pointer to "last granted = r1", giving r0 priority first.
REQ-033 Reset mid-operation SHALL discard in-flight read returns; no rvalid is produced for them after reset.
REQ-034 Reset mid-operation SHALL leave the write granted in the cycle before reset rose unaffected at memory.

Verification
REQ-035 Reset, then r0 read addr 9216 alone with RD_LAT=1 -> r0_gnt in cycle 0, mem_addr=9216/mem_we=0 in cycle 1, r0_rvalid in cycle 2 with r0_rdata=mem_rdata; r1_rvalid stays 0.
REQ-036 r0 and r1 both request continuously from reset for 6 cycles -> grants alternate r0,r1,r0,r1,r0,r1; never both high.
REQ-037 r1 write addr 5 data 16'hBEEF, then r0 read addr 5 in the next cycle -> mem_we=1 with 5/BEEF, then read of 5; r0_rdata=16'hBEEF with the model memory.
REQ-038 RD_LAT=3, r0 reads 100, 101, 102 back-to-back -> r0_rvalid in cycles 4, 5, 6 in order, 3 cycles wide total.
REQ-039 r1 read granted, reset asserted the following cycle for 1 cycle -> no r1_rvalid ever; next contested grant goes to r0.
REQ-040 Idle for 4 cycles after a write to addr 7 -> mem_we=0, mem_addr holds 7 throughout.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: a core (r0) and a secondary requester (r1) share one
// single-ported memory. Grants are combinational and alternate under contention,
// the chosen access is registered onto the memory bus, and read returns are
// steered back to the right port by a small tag pipeline matched to RD_LAT.
module mem_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r0_we,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,

  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  input  logic              r1_we,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  // One tag slot per cycle between the grant edge and the cycle the data
  // arrives; the last slot lines up with mem_rdata.
  localparam int DEPTH = RD_LAT + 1;

  // 1 when r1 won the most recent grant, so r0 wins the next tie.
  logic last_r1;

  logic              any_gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

  logic [DEPTH-1:0] tag_valid;
  logic [DEPTH-1:0] tag_id;

  // Grant decision: a lone requester always wins, a tie goes to whoever
  // did not win last time, and nothing is granted while reset is high.
  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    if (!reset) begin
      if (r0_req && r1_req) begin
        r0_gnt = last_r1;
        r1_gnt = !last_r1;
      end else begin
        r0_gnt = r0_req;
        r1_gnt = r1_req;
      end
    end
  end

  // Select the winning requester's access fields for the memory bus.
  always_comb begin
    any_gnt   = r0_gnt | r1_gnt;
    sel_addr  = r0_addr;
    sel_wdata = r0_wdata;
    sel_we    = r0_we;
    if (r1_gnt) begin
      sel_addr  = r1_addr;
      sel_wdata = r1_wdata;
      sel_we    = r1_we;
    end
  end

  // Fairness pointer: only moves when someone is actually granted.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_r1 <= 1'b1;
    end else if (r0_gnt) begin
      last_r1 <= 1'b0;
    end else if (r1_gnt) begin
      last_r1 <= 1'b1;
    end
  end

  // Memory bus register: load on a grant, otherwise drop the write enable
  // and leave address/data parked where they were.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else if (any_gnt) begin
      mem_addr  <= sel_addr;
      mem_wdata <= sel_wdata;
      mem_we    <= sel_we;
    end else begin
      mem_we    <= 1'b0;
    end
  end

  // Read-return tag pipeline: each granted read enters with its port id and
  // shifts one slot per cycle; writes and idle cycles enter as empty slots.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      tag_valid <= {tag_valid[DEPTH-2:0], any_gnt & ~sel_we};
      tag_id    <= {tag_id[DEPTH-2:0], r1_gnt};
    end
  end

  // Data is broadcast to both ports; only the strobe is steered by the tag.
  always_comb begin
    r0_rvalid = tag_valid[RD_LAT] & ~tag_id[RD_LAT];
    r1_rvalid = tag_valid[RD_LAT] &  tag_id[RD_LAT];
    r0_rdata  = mem_rdata;
    r1_rdata  = mem_rdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: two instances (RD_LAT=1 and RD_LAT=3) share the
// same stimulus, each with its own memory and its own transaction-level model.
module tb_mem_arbiter;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic              r0_req = 1'b0, r1_req = 1'b0;
  logic [ADDR_W-1:0] r0_addr = '0, r1_addr = '0;
  logic [DATA_W-1:0] r0_wdata = '0, r1_wdata = '0;
  logic              r0_we = 1'b0, r1_we = 1'b0;

  logic              r0_gnt_v    [2];
  logic              r1_gnt_v    [2];
  logic              r0_rvalid_v [2];
  logic              r1_rvalid_v [2];
  logic [DATA_W-1:0] r0_rdata_v  [2];
  logic [DATA_W-1:0] r1_rdata_v  [2];
  logic [ADDR_W-1:0] mem_addr_v  [2];
  logic [DATA_W-1:0] mem_wdata_v [2];
  logic              mem_we_v    [2];
  logic [DATA_W-1:0] mem_rdata_v [2];

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  // Power-up contents of every memory location.
  function automatic logic [DATA_W-1:0] init_val(input int a);
    int t;
    t = (a * 40503) ^ 23130;
    return t[DATA_W-1:0];
  endfunction

  // Which port should win this cycle: -1 none, 0 or 1.
  function automatic int winner(input logic q0, input logic q1, input logic rst, input int last);
    if (rst) return -1;
    if (q0 && q1) return (last == 1) ? 0 : 1;
    if (q0) return 0;
    if (q1) return 1;
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then wait for the
  // falling edge where outputs are sampled.
  task automatic applyStimulus(
    input logic q0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0, input logic w0,
    input logic q1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1, input logic w1,
    input logic rst);
    @(posedge clock);
    #1;
    r0_req = q0; r0_addr = a0; r0_wdata = d0; r0_we = w0;
    r1_req = q1; r1_addr = a1; r1_wdata = d1; r1_we = w1;
    reset = rst;
    @(negedge clock);
  endtask

  task automatic idleCycle(input logic rst);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, rst);
  endtask

  typedef struct {
    int                due;
    int                port;
    logic [DATA_W-1:0] data;
  } ret_t;

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int LAT = (g == 0) ? 1 : 3;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(LAT)) dut (
      .clock     (clock),
      .reset     (reset),
      .r0_req    (r0_req),
      .r0_addr   (r0_addr),
      .r0_wdata  (r0_wdata),
      .r0_we     (r0_we),
      .r0_gnt    (r0_gnt_v[g]),
      .r0_rvalid (r0_rvalid_v[g]),
      .r0_rdata  (r0_rdata_v[g]),
      .r1_req    (r1_req),
      .r1_addr   (r1_addr),
      .r1_wdata  (r1_wdata),
      .r1_we     (r1_we),
      .r1_gnt    (r1_gnt_v[g]),
      .r1_rvalid (r1_rvalid_v[g]),
      .r1_rdata  (r1_rdata_v[g]),
      .mem_addr  (mem_addr_v[g]),
      .mem_wdata (mem_wdata_v[g]),
      .mem_we    (mem_we_v[g]),
      .mem_rdata (mem_rdata_v[g])
    );

    // Memory with LAT cycles from address to data.
    logic [DATA_W-1:0] mem  [2**ADDR_W];
    logic [DATA_W-1:0] pipe [LAT];

    initial begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] = init_val(i);
      for (int i = 0; i < LAT; i++) pipe[i] = '0;
    end

    always @(posedge clock) begin
      if (mem_we_v[g]) mem[mem_addr_v[g]] <= mem_wdata_v[g];
      pipe[0] <= mem[mem_addr_v[g]];
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign mem_rdata_v[g] = pipe[LAT-1];

    // Transaction-level model: grants in order, contents of memory as seen
    // in grant order, and a list of expected returns with their due cycle.
    int                cyc    = 0;
    int                m_last = 1;
    logic [ADDR_W-1:0] e_addr = '0;
    logic [DATA_W-1:0] e_wdata = '0;
    logic              e_we   = 1'b0;
    logic [DATA_W-1:0] shadow [2**ADDR_W];
    ret_t              q [$];

    initial begin
      for (int i = 0; i < 2**ADDR_W; i++) shadow[i] = init_val(i);
    end

    always @(posedge clock) begin
      int                w;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic              we;
      ret_t              e;
      w = winner(r0_req, r1_req, reset, m_last);
      if (reset) begin
        q.delete();
        m_last  = 1;
        e_addr  = '0;
        e_wdata = '0;
        e_we    = 1'b0;
      end else if (w >= 0) begin
        a  = (w == 1) ? r1_addr  : r0_addr;
        d  = (w == 1) ? r1_wdata : r0_wdata;
        we = (w == 1) ? r1_we    : r0_we;
        e_addr  = a;
        e_wdata = d;
        e_we    = we;
        if (we) begin
          shadow[a] = d;
        end else begin
          e.due  = cyc + 1 + LAT;
          e.port = w;
          e.data = shadow[a];
          q.push_back(e);
        end
        m_last = w;
      end else begin
        e_we = 1'b0;
      end
      cyc++;
    end

    always @(negedge clock) begin
      int                w;
      logic              x0, x1;
      logic [DATA_W-1:0] xd;
      if (cyc > 0) begin
        w = winner(r0_req, r1_req, reset, m_last);
        checkOutput($sformatf("L%0d r0_gnt", LAT), 32'(r0_gnt_v[g]), 32'(w == 0));
        checkOutput($sformatf("L%0d r1_gnt", LAT), 32'(r1_gnt_v[g]), 32'(w == 1));
        checkOutput($sformatf("L%0d mem_we", LAT), 32'(mem_we_v[g]), 32'(e_we));
        checkOutput($sformatf("L%0d mem_addr", LAT), 32'(mem_addr_v[g]), 32'(e_addr));
        checkOutput($sformatf("L%0d mem_wdata", LAT), 32'(mem_wdata_v[g]), 32'(e_wdata));
        x0 = 1'b0;
        x1 = 1'b0;
        xd = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
          x0 = (q[0].port == 0);
          x1 = (q[0].port == 1);
          xd = q[0].data;
          void'(q.pop_front());
        end
        checkOutput($sformatf("L%0d r0_rvalid", LAT), 32'(r0_rvalid_v[g]), 32'(x0));
        checkOutput($sformatf("L%0d r1_rvalid", LAT), 32'(r1_rvalid_v[g]), 32'(x1));
        if (x0) checkOutput($sformatf("L%0d r0_rdata", LAT), 32'(r0_rdata_v[g]), 32'(xd));
        if (x1) checkOutput($sformatf("L%0d r1_rdata", LAT), 32'(r1_rdata_v[g]), 32'(xd));
      end
    end
  end

  typedef struct {
    logic q0;
    logic q1;
    logic e0;
    logic e1;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int cnt, first, cnt1;
    logic g0, g1, q0, q1, w0, w1, rst;
    logic [ADDR_W-1:0] a0, a1;
    logic [DATA_W-1:0] d0, d1;

    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0};

    $display("[TB] reset");
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset mem_we", 32'(mem_we_v[0]), 32'd0);
    checkOutput("reset mem_addr", 32'(mem_addr_v[0]), 32'd0);
    checkOutput("reset r0_gnt", 32'(r0_gnt_v[0]), 32'd0);

    $display("[TB] grant table from reset");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].q0, ADDR_W'($urandom_range(0, 31)), DATA_W'($urandom), 1'($urandom),
                    vecs[i].q1, ADDR_W'($urandom_range(0, 31)), DATA_W'($urandom), 1'($urandom), 1'b0);
      for (int k = 0; k < 2; k++) begin
        checkOutput($sformatf("table[%0d] r0_gnt L%0d", i, k), 32'(r0_gnt_v[k]), 32'(vecs[i].e0));
        checkOutput($sformatf("table[%0d] r1_gnt L%0d", i, k), 32'(r1_gnt_v[k]), 32'(vecs[i].e1));
      end
    end

    $display("[TB] lone read of 9216");
    idleCycle(1'b1);
    applyStimulus(1'b1, 15'd9216, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("rd9216 gnt", 32'(r0_gnt_v[0]), 32'd1);
    idleCycle(1'b0);
    checkOutput("rd9216 mem_addr", 32'(mem_addr_v[0]), 32'd9216);
    checkOutput("rd9216 mem_we", 32'(mem_we_v[0]), 32'd0);
    idleCycle(1'b0);
    checkOutput("rd9216 rvalid", 32'(r0_rvalid_v[0]), 32'd1);
    checkOutput("rd9216 rdata", 32'(r0_rdata_v[0]), 32'(init_val(9216)));
    checkOutput("rd9216 r1_rvalid", 32'(r1_rvalid_v[0]), 32'd0);
    repeat (3) idleCycle(1'b0);

    $display("[TB] write then read of address 5");
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 15'd5, 16'hBEEF, 1'b1, 1'b0);
    checkOutput("wr5 r1_gnt", 32'(r1_gnt_v[0]), 32'd1);
    applyStimulus(1'b1, 15'd5, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("rd5 r0_gnt", 32'(r0_gnt_v[0]), 32'd1);
    checkOutput("wr5 mem_we", 32'(mem_we_v[0]), 32'd1);
    checkOutput("wr5 mem_addr", 32'(mem_addr_v[0]), 32'd5);
    checkOutput("wr5 mem_wdata", 32'(mem_wdata_v[0]), 32'hBEEF);
    idleCycle(1'b0);
    checkOutput("rd5 mem_we", 32'(mem_we_v[0]), 32'd0);
    checkOutput("rd5 mem_addr", 32'(mem_addr_v[0]), 32'd5);
    idleCycle(1'b0);
    checkOutput("rd5 L1 rvalid", 32'(r0_rvalid_v[0]), 32'd1);
    checkOutput("rd5 L1 rdata", 32'(r0_rdata_v[0]), 32'hBEEF);
    idleCycle(1'b0);
    idleCycle(1'b0);
    checkOutput("rd5 L3 rvalid", 32'(r0_rvalid_v[1]), 32'd1);
    checkOutput("rd5 L3 rdata", 32'(r0_rdata_v[1]), 32'hBEEF);
    repeat (2) idleCycle(1'b0);

    $display("[TB] back-to-back reads 100..102");
    cnt   = 0;
    first = -1;
    for (int c = 0; c < 10; c++) begin
      if (c < 3) applyStimulus(1'b1, ADDR_W'(100 + c), '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      else idleCycle(1'b0);
      if (r0_rvalid_v[1]) begin
        cnt++;
        if (first < 0) first = c;
      end
    end
    checkOutput("b2b L3 rvalid count", 32'(cnt), 32'd3);
    checkOutput("b2b L3 first rvalid cycle", 32'(first), 32'd4);

    $display("[TB] reset discards in-flight read");
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 15'd77, '0, 1'b0, 1'b0);
    checkOutput("rst r1_gnt", 32'(r1_gnt_v[0]), 32'd1);
    idleCycle(1'b1);
    cnt  = 0;
    cnt1 = 0;
    for (int c = 0; c < 6; c++) begin
      idleCycle(1'b0);
      if (r1_rvalid_v[0]) cnt++;
      if (r1_rvalid_v[1]) cnt1++;
    end
    checkOutput("rst L1 r1_rvalid count", 32'(cnt), 32'd0);
    checkOutput("rst L3 r1_rvalid count", 32'(cnt1), 32'd0);
    applyStimulus(1'b1, 15'd3, '0, 1'b0, 1'b1, 15'd4, '0, 1'b0, 1'b0);
    checkOutput("rst contest L1 r0_gnt", 32'(r0_gnt_v[0]), 32'd1);
    checkOutput("rst contest L3 r0_gnt", 32'(r0_gnt_v[1]), 32'd1);
    repeat (4) idleCycle(1'b0);

    $display("[TB] idle after write to 7");
    applyStimulus(1'b1, 15'd7, 16'h1234, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      idleCycle(1'b0);
      if (c >= 2) begin
        checkOutput($sformatf("idle%0d mem_we", c), 32'(mem_we_v[0]), 32'd0);
        checkOutput($sformatf("idle%0d mem_addr", c), 32'(mem_addr_v[0]), 32'd7);
      end
    end

    $display("[TB] randomized traffic");
    g0 = 1'b1; g1 = 1'b1;
    q0 = 1'b0; q1 = 1'b0; w0 = 1'b0; w1 = 1'b0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    for (int c = 0; c < 400; c++) begin
      if (!(q0 && !g0)) begin
        q0 = ($urandom_range(0, 2) != 0);
        a0 = ADDR_W'($urandom_range(0, 63));
        d0 = DATA_W'($urandom);
        w0 = 1'($urandom);
      end
      if (!(q1 && !g1)) begin
        q1 = ($urandom_range(0, 2) != 0);
        a1 = ADDR_W'($urandom_range(0, 63));
        d1 = DATA_W'($urandom);
        w1 = 1'($urandom);
      end
      rst = ($urandom_range(0, 49) == 0);
      applyStimulus(q0, a0, d0, w0, q1, a1, d1, w1, rst);
      g0 = r0_gnt_v[0];
      g1 = r1_gnt_v[0];
    end
    repeat (6) idleCycle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
